route_sequencer: RTL and testbench

//  Mission-level controller around the Dijkstra path planner. Queues goal nodes and requests a plan for each leg
//  (current node -> goal). Walks the returned node list, converts each edge into a robot turn command against the

---
 rtl/route_pkg.sv | 62 ++++++
 rtl/route_sequencer_edge_heading.sv | 46 ++++
 rtl/route_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_route_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/route_pkg.sv
// Shared definitions for the route sequencer.
// Holds the command/direction encodings and the turn table. It also holds the arena
// coordinate ROMs (x grows to the north, y grows to the east) and the list of diagonal
// edges with the heading the robot has when it leaves each one.
package route_pkg;

    localparam int N_NODES = 37;

    localparam logic [1:0] CMD_STRAIGHT = 2'b00;
    localparam logic [1:0] CMD_LEFT     = 2'b01;
    localparam logic [1:0] CMD_RIGHT    = 2'b10;
    localparam logic [1:0] CMD_BACK     = 2'b11;

    localparam logic [1:0] DIR_W = 2'b00;
    localparam logic [1:0] DIR_E = 2'b01;
    localparam logic [1:0] DIR_N = 2'b10;
    localparam logic [1:0] DIR_S = 2'b11;

    // Edge classification returned by edge_heading.
    typedef struct packed {
        logic       valid;
        logic       diag;
        logic [1:0] dir;
    } edge_info_t;

    // TURN_LUT[current heading][target direction] -> command.
    localparam logic [1:0] TURN_LUT [4][4] = '{
        '{2'd0, 2'd3, 2'd2, 2'd1},   // facing W
        '{2'd3, 2'd0, 2'd1, 2'd2},   // facing E
        '{2'd1, 2'd2, 2'd0, 2'd3},   // facing N
        '{2'd2, 2'd1, 2'd3, 2'd0}    // facing S
    };

    localparam logic [2:0] NODE_X [N_NODES] = '{
        3'd6, 3'd6, 3'd6, 3'd5, 3'd6, 3'd5, 3'd6, 3'd5, 3'd5, 3'd5,
        3'd4, 3'd3, 3'd2, 3'd1, 3'd0,
        3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4,
        3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3,
        3'd2, 3'd2, 3'd2, 3'd2,
        3'd1, 3'd1,
        3'd0, 3'd0, 3'd0, 3'd0
    };

    localparam logic [2:0] NODE_Y [N_NODES] = '{
        3'd3, 3'd0, 3'd1, 3'd1, 3'd5, 3'd6, 3'd6, 3'd0, 3'd2, 3'd3,
        3'd3, 3'd3, 3'd3, 3'd3, 3'd3,
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6,
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6,
        3'd0, 3'd2, 3'd4, 3'd6,
        3'd0, 3'd6,
        3'd0, 3'd2, 3'd4, 3'd6
    };

    // Diagonal edges: the robot drives straight along them and ends up with DIAG_DIR.
    localparam int N_DIAG = 8;
    localparam int DIAG_FROM [N_DIAG] = '{0, 8, 2, 3, 4, 5, 7, 8};
    localparam int DIAG_TO   [N_DIAG] = '{8, 0, 3, 2, 5, 4, 8, 7};
    localparam logic [1:0] DIAG_DIR [N_DIAG] = '{
        DIR_S, DIR_N, DIR_S, DIR_N, DIR_S, DIR_E, DIR_S, DIR_W
    };

endpackage

// File: rtl/route_sequencer_edge_heading.sv
// Combinational edge classifier.
// Ports: from_node/to_node (edge endpoints) -> valid (edge is drivable),
//        diag (edge is in the diagonal table), dir (heading after the edge).
// The diagonal table takes precedence. Otherwise the two nodes must share a row or
// a column of the coordinate ROM.
module route_sequencer_edge_heading
    import route_pkg::*;
#(
    parameter int NODE_W = 6
) (
    input  logic [NODE_W-1:0] from_node,
    input  logic [NODE_W-1:0] to_node,
    output edge_info_t        info
);

    logic [2:0] fx, fy, tx, ty;

    always_comb begin
        info = '0;
        fx   = '0;
        fy   = '0;
        tx   = '0;
        ty   = '0;
        for (int i = 0; i < N_DIAG; i++) begin
            if (int'(from_node) == DIAG_FROM[i] && int'(to_node) == DIAG_TO[i]) begin
                info.valid = 1'b1;
                info.diag  = 1'b1;
                info.dir   = DIAG_DIR[i];
            end
        end
        if (!info.diag && int'(from_node) < N_NODES && int'(to_node) < N_NODES) begin
            fx = NODE_X[from_node];
            fy = NODE_Y[from_node];
            tx = NODE_X[to_node];
            ty = NODE_Y[to_node];
            if (fy == ty && fx != tx) begin
                info.valid = 1'b1;
                info.dir   = (tx > fx) ? DIR_N : DIR_S;
            end else if (fx == tx && fy != ty) begin
                info.valid = 1'b1;
                info.dir   = (ty < fy) ? DIR_W : DIR_E;
            end
        end
    end

endmodule

// File: rtl/route_sequencer.sv
// Mission controller around the path planner.
// Ports: goal_* (goal FIFO push), start/abort (mission control),
//        plan_* / path_* (planner request and path buffer read-back),
//        cmd_* / move_done (motion unit handshake), heading/cur_node/busy/
//        mission_done/error (status).
// Handshakes: goal push happens on goal_valid && goal_ready, and a command is taken on
// cmd_valid && cmd_ready. Both sides hold their data stable while valid is high and not
// yet accepted. plan_req is a single-cycle pulse, and plan_start/plan_end stay constant
// until plan_done.
module route_sequencer
    import route_pkg::*;
#(
    parameter int NODE_W     = 6,
    parameter int GOAL_DEPTH = 8,
    parameter int HOME_NODE  = 0
) (
    input  logic              clk_50,
    input  logic              rst_n,
    input  logic              goal_valid,
    input  logic [NODE_W-1:0] goal_node,
    output logic              goal_ready,
    input  logic              start,
    input  logic              abort,
    output logic              plan_req,
    output logic [NODE_W-1:0] plan_start,
    output logic [NODE_W-1:0] plan_end,
    input  logic              plan_done,
    input  logic [NODE_W-1:0] path_len,
    output logic [NODE_W-1:0] path_rd_idx,
    input  logic [NODE_W-1:0] path_rd_node,
    output logic              cmd_valid,
    output logic [1:0]        cmd,
    input  logic              cmd_ready,
    input  logic              move_done,
    output logic [1:0]        heading,
    output logic [NODE_W-1:0] cur_node,
    output logic              busy,
    output logic              mission_done,
    output logic              error
);

    localparam int PTR_W = $clog2(GOAL_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_PLAN  = 4'd1;
    localparam logic [3:0] S_PWAIT = 4'd2;
    localparam logic [3:0] S_RD    = 4'd3;
    localparam logic [3:0] S_CALC  = 4'd4;
    localparam logic [3:0] S_ISSUE = 4'd5;
    localparam logic [3:0] S_MWAIT = 4'd6;
    localparam logic [3:0] S_NEXTG = 4'd7;
    localparam logic [3:0] S_FIN   = 4'd8;

    logic [3:0]        state;
    logic [NODE_W-1:0] fifo_mem [GOAL_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [NODE_W-1:0] k;            // edges still to drive on this leg
    logic [NODE_W-1:0] next_node;
    logic [1:0]        dir_q;
    logic [1:0]        cmd_q;
    logic              plan_req_q;
    logic              push, pop, fifo_empty;
    edge_info_t        edge_info;

    route_sequencer_edge_heading #(.NODE_W(NODE_W)) u_edge (
        .from_node (cur_node),
        .to_node   (path_rd_node),
        .info      (edge_info)
    );

    // Abort flushes the FIFO, so a push in that cycle is refused rather than lost.
    assign goal_ready   = (count != CNT_W'(GOAL_DEPTH)) && !abort;
    assign push         = goal_valid && goal_ready;
    assign pop          = (state == S_PLAN) && !abort;
    assign fifo_empty   = (count == '0);

    // Abort withdraws requests in the same cycle it is seen.
    assign plan_req     = plan_req_q && !abort;
    assign cmd_valid    = (state == S_ISSUE) && !abort;
    assign mission_done = (state == S_FIN) && !abort;
    assign cmd          = cmd_q;
    assign busy         = (state != S_IDLE);
    // Path buffer is read synchronously: the address is shown in RD, data arrives in CALC.
    assign path_rd_idx  = (state == S_RD) ? (k - 1'b1) : '0;

    always_ff @(posedge clk_50) begin
        if (push) begin
            fifo_mem[wr_ptr] <= goal_node;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            plan_req_q <= 1'b0;
            plan_start <= '0;
            plan_end   <= '0;
            k          <= '0;
            next_node  <= '0;
            dir_q      <= DIR_W;
            cmd_q      <= CMD_STRAIGHT;
            heading    <= DIR_W;
            cur_node   <= NODE_W'(HOME_NODE);
            error      <= 1'b0;
        end else if (abort) begin
            // Heading and position keep their last committed values.
            state      <= S_IDLE;
            plan_req_q <= 1'b0;
        end else begin
            plan_req_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        state <= fifo_empty ? S_FIN : S_PLAN;
                    end
                end
                S_PLAN: begin
                    plan_start <= cur_node;
                    plan_end   <= fifo_mem[rd_ptr];
                    plan_req_q <= 1'b1;
                    state      <= S_PWAIT;
                end
                S_PWAIT: begin
                    if (plan_done) begin
                        if (path_len == '0) begin
                            error <= 1'b1;
                            state <= S_FIN;
                        end else if (path_len == NODE_W'(1)) begin
                            state <= S_NEXTG;
                        end else begin
                            k     <= path_len - 1'b1;
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    state <= S_CALC;
                end
                S_CALC: begin
                    if (!edge_info.valid) begin
                        error <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        next_node <= path_rd_node;
                        dir_q     <= edge_info.dir;
                        cmd_q     <= edge_info.diag ? CMD_STRAIGHT
                                                    : TURN_LUT[heading][edge_info.dir];
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        heading <= dir_q;
                        state   <= S_MWAIT;
                    end
                end
                S_MWAIT: begin
                    if (move_done) begin
                        cur_node <= next_node;
                        k        <= k - 1'b1;
                        state    <= (k == NODE_W'(1)) ? S_NEXTG : S_RD;
                    end
                end
                S_NEXTG: begin
                    state <= fifo_empty ? S_FIN : S_PLAN;
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_route_sequencer.sv
// Self-checking bench for route_sequencer. The bench models the planner and the
// motion unit. Expected planner requests, accepted commands and mission completions
// are queued when stimulus is issued, and a monitor compares them as the DUT shows them.
module tb_route_sequencer;

  localparam logic [1:0] H_W = 2'd0, H_E = 2'd1, H_N = 2'd2, H_S = 2'd3;
  localparam logic [1:0] C_STR = 2'd0, C_LEFT = 2'd1, C_BACK = 2'd3;

  logic       clk_50, rst_n;
  logic       goal_valid, goal_ready, start, abort;
  logic [5:0] goal_node;
  logic       plan_req, plan_done;
  logic [5:0] plan_start, plan_end, path_len, path_rd_idx, path_rd_node;
  logic       cmd_valid, cmd_ready, move_done;
  logic [1:0] cmd, heading;
  logic [5:0] cur_node;
  logic       busy, mission_done, error;

  route_sequencer dut (
    .clk_50(clk_50), .rst_n(rst_n),
    .goal_valid(goal_valid), .goal_node(goal_node), .goal_ready(goal_ready),
    .start(start), .abort(abort),
    .plan_req(plan_req), .plan_start(plan_start), .plan_end(plan_end),
    .plan_done(plan_done), .path_len(path_len),
    .path_rd_idx(path_rd_idx), .path_rd_node(path_rd_node),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready), .move_done(move_done),
    .heading(heading), .cur_node(cur_node), .busy(busy),
    .mission_done(mission_done), .error(error)
  );

  // ---------------- clock / reset ----------------
  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  logic [29:0] resp_q[$];       // planner answers: {len, buf3, buf2, buf1, buf0}
  logic [5:0]  path_buf [64];
  bit motion_auto = 1'b1;
  bit hold_move   = 1'b0;

  task automatic wait_cycle();
    @(posedge clk_50);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [15:0] ev_plan(input logic [5:0] s, input logic [5:0] e);
    return {2'd1, 2'd0, s, e};
  endfunction

  function automatic logic [15:0] ev_cmd(input logic [1:0] c);
    return {2'd2, c, 12'd0};
  endfunction

  function automatic logic [15:0] ev_done(input logic err, input logic [1:0] h, input logic [5:0] n);
    return {2'd3, h, 5'd0, err, n};
  endfunction

  function automatic logic [29:0] resp(input logic [5:0] len, input logic [5:0] b0,
                                       input logic [5:0] b1, input logic [5:0] b2,
                                       input logic [5:0] b3);
    return {len, b3, b2, b1, b0};
  endfunction

  // ---------------- scoreboard monitor ----------------
  task automatic sb_check(input string name, input logic [15:0] act);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: unexpected event %0h", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, {16'd0, act}, {16'd0, e});
    end
  endtask

  always @(negedge clk_50) begin
    if (rst_n) begin
      if (plan_req) sb_check("plan_req", ev_plan(plan_start, plan_end));
      if (cmd_valid && cmd_ready) sb_check("cmd_accept", ev_cmd(cmd));
      if (mission_done) sb_check("mission_done", ev_done(error, heading, cur_node));
    end
  end

  // ---------------- planner model ----------------
  always @(posedge clk_50) path_rd_node <= path_buf[path_rd_idx];

  initial begin
    logic [29:0] r;
    plan_done = 1'b0;
    path_len  = '0;
    for (int i = 0; i < 64; i++) path_buf[i] = '0;
    forever begin
      @(negedge clk_50);
      if (rst_n && plan_req) begin
        if (resp_q.size() == 0) begin
          timeout_fail("planner response missing");
          r = '0;
        end else begin
          r = resp_q.pop_front();
        end
        repeat (3) wait_cycle();
        path_buf[0] = r[5:0];
        path_buf[1] = r[11:6];
        path_buf[2] = r[17:12];
        path_buf[3] = r[23:18];
        path_len    = r[29:24];
        plan_done   = 1'b1;
        wait_cycle();
        plan_done   = 1'b0;
      end
    end
  end

  // ---------------- motion model ----------------
  initial begin
    cmd_ready = 1'b0;
    move_done = 1'b0;
    forever begin
      wait_cycle();
      if (motion_auto && rst_n && cmd_valid) begin
        repeat ($urandom_range(0, 2)) wait_cycle();
        cmd_ready = 1'b1;
        wait_cycle();
        cmd_ready = 1'b0;
        repeat (2) wait_cycle();
        if (!hold_move) begin
          move_done = 1'b1;
          wait_cycle();
          move_done = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_goal(input logic [5:0] n, input logic exp_ok);
    goal_valid = 1'b1;
    goal_node  = n;
    @(negedge clk_50);
    check("goal_ready", {31'd0, goal_ready}, {31'd0, exp_ok});
    wait_cycle();
    goal_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    wait_cycle();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk_50);
      if (!busy) seen = 1'b1;
    end
    if (!seen) timeout_fail(name);
    wait_cycle();
  endtask

  task automatic wait_accept(input int max_cycles, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk_50);
      if (cmd_valid && cmd_ready) seen = 1'b1;
    end
    if (!seen) timeout_fail(name);
    wait_cycle();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " goal_ready"},   {31'd0, goal_ready},   32'd1);
    check({tag, " plan_req"},     {31'd0, plan_req},     32'd0);
    check({tag, " plan_start"},   {26'd0, plan_start},   32'd0);
    check({tag, " plan_end"},     {26'd0, plan_end},     32'd0);
    check({tag, " path_rd_idx"},  {26'd0, path_rd_idx},  32'd0);
    check({tag, " cmd_valid"},    {31'd0, cmd_valid},    32'd0);
    check({tag, " cmd"},          {30'd0, cmd},          32'd0);
    check({tag, " heading"},      {30'd0, heading},      {30'd0, H_W});
    check({tag, " cur_node"},     {26'd0, cur_node},     32'd0);
    check({tag, " busy"},         {31'd0, busy},         32'd0);
    check({tag, " mission_done"}, {31'd0, mission_done}, 32'd0);
    check({tag, " error"},        {31'd0, error},        32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst_n = 1'b0; goal_valid = 1'b0; goal_node = '0; start = 1'b0; abort = 1'b0;
    repeat (3) wait_cycle();
    @(negedge clk_50);
    check_reset_vals("reset");
    wait_cycle();
    rst_n = 1'b1;
    wait_cycle();

    // 1: single goal 11, path 0->9->10->11 heading south.
    resp_q.push_back(resp(6'd4, 6'd11, 6'd10, 6'd9, 6'd0));
    exp_q.push_back(ev_plan(6'd0, 6'd11));
    exp_q.push_back(ev_cmd(C_LEFT));
    exp_q.push_back(ev_cmd(C_STR));
    exp_q.push_back(ev_cmd(C_STR));
    exp_q.push_back(ev_done(1'b0, H_S, 6'd11));
    push_goal(6'd11, 1'b1);
    pulse_start();
    wait_idle(400, "test1 idle");

    // 2: from home, goals 11 then 0; second leg starts with a U-turn.
    rst_n = 1'b0;
    wait_cycle();
    rst_n = 1'b1;
    wait_cycle();
    resp_q.push_back(resp(6'd4, 6'd11, 6'd10, 6'd9, 6'd0));
    resp_q.push_back(resp(6'd4, 6'd0, 6'd9, 6'd10, 6'd11));
    exp_q.push_back(ev_plan(6'd0, 6'd11));
    exp_q.push_back(ev_cmd(C_LEFT));
    exp_q.push_back(ev_cmd(C_STR));
    exp_q.push_back(ev_cmd(C_STR));
    exp_q.push_back(ev_plan(6'd11, 6'd0));
    exp_q.push_back(ev_cmd(C_BACK));
    exp_q.push_back(ev_cmd(C_STR));
    exp_q.push_back(ev_cmd(C_STR));
    exp_q.push_back(ev_done(1'b0, H_N, 6'd0));
    push_goal(6'd11, 1'b1);
    push_goal(6'd0, 1'b1);
    pulse_start();
    wait_idle(800, "test2 idle");

    // 3: goal 9 facing north -> back; cmd held without ready, stray move_done ignored.
    motion_auto = 1'b0;
    resp_q.push_back(resp(6'd2, 6'd9, 6'd0, 6'd0, 6'd0));
    exp_q.push_back(ev_plan(6'd0, 6'd9));
    exp_q.push_back(ev_cmd(C_BACK));
    exp_q.push_back(ev_done(1'b0, H_S, 6'd9));
    push_goal(6'd9, 1'b1);
    pulse_start();
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk_50);
        if (cmd_valid) seen = 1'b1;
      end
      if (!seen) timeout_fail("test3 cmd_valid");
    end
    for (int i = 0; i < 5; i++) begin
      wait_cycle();
      move_done = (i == 2);
      @(negedge clk_50);
      check("hold cmd_valid", {31'd0, cmd_valid}, 32'd1);
      check("hold cmd", {30'd0, cmd}, {30'd0, C_BACK});
      check("hold cur_node", {26'd0, cur_node}, 32'd0);
    end
    wait_cycle();
    move_done = 1'b0;
    cmd_ready = 1'b1;
    wait_cycle();
    cmd_ready = 1'b0;
    wait_cycle();
    move_done = 1'b1;
    wait_cycle();
    move_done = 1'b0;
    wait_idle(100, "test3 idle");
    motion_auto = 1'b1;

    // 4: unreachable goal 20 -> error, no command; next start clears error.
    resp_q.push_back(resp(6'd0, 6'd0, 6'd0, 6'd0, 6'd0));
    exp_q.push_back(ev_plan(6'd9, 6'd20));
    exp_q.push_back(ev_done(1'b1, H_S, 6'd9));
    push_goal(6'd20, 1'b1);
    pulse_start();
    wait_idle(100, "test4 idle");
    @(negedge clk_50);
    check("error sticky", {31'd0, error}, 32'd1);
    exp_q.push_back(ev_done(1'b0, H_S, 6'd9));
    wait_cycle();
    pulse_start();
    wait_idle(50, "test4 restart idle");
    @(negedge clk_50);
    check("error cleared", {31'd0, error}, 32'd0);
    wait_cycle();

    // 5: fill FIFO (9th refused), then abort while waiting for the move.
    hold_move = 1'b1;
    push_goal(6'd10, 1'b1);
    for (int i = 1; i <= 7; i++) push_goal(6'(i), 1'b1);
    push_goal(6'd20, 1'b0);
    resp_q.push_back(resp(6'd2, 6'd10, 6'd9, 6'd0, 6'd0));
    exp_q.push_back(ev_plan(6'd9, 6'd10));
    exp_q.push_back(ev_cmd(C_STR));
    pulse_start();
    wait_accept(100, "test5 accept");
    repeat (3) wait_cycle();
    abort = 1'b1;
    wait_cycle();
    abort = 1'b0;
    @(negedge clk_50);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort goal_ready", {31'd0, goal_ready}, 32'd1);
    check("abort cur_node", {26'd0, cur_node}, 32'd9);
    check("abort heading", {30'd0, heading}, {30'd0, H_S});
    exp_q.push_back(ev_done(1'b0, H_S, 6'd9));
    wait_cycle();
    pulse_start();
    wait_idle(50, "test5 flushed idle");

    // 6: diagonal 0->8 from home, then reset during the move.
    rst_n = 1'b0;
    wait_cycle();
    rst_n = 1'b1;
    wait_cycle();
    resp_q.push_back(resp(6'd2, 6'd8, 6'd0, 6'd0, 6'd0));
    exp_q.push_back(ev_plan(6'd0, 6'd8));
    exp_q.push_back(ev_cmd(C_STR));
    push_goal(6'd8, 1'b1);
    pulse_start();
    wait_accept(100, "test6 accept");
    repeat (2) wait_cycle();
    @(negedge clk_50);
    check("diag heading", {30'd0, heading}, {30'd0, H_S});
    check("diag busy", {31'd0, busy}, 32'd1);
    wait_cycle();
    rst_n = 1'b0;
    @(negedge clk_50);
    check_reset_vals("mid-move reset");
    wait_cycle();
    rst_n = 1'b1;
    repeat (2) wait_cycle();

    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
